// File: rtl/fsk_nco_modulator_if.sv
// Bit-stream handshake between the framing logic and the FSK modulator.
//   bit_data  : bit to transmit (producer -> modulator)
//   bit_valid : bit_data is valid (producer -> modulator)
//   bit_ready : modulator FIFO can accept a bit (modulator -> producer)
// Modports:
//   master : the bit producer (framing logic or testbench)
//   slave  : the modulator
interface fsk_nco_modulator_if;
  logic bit_data;
  logic bit_valid;
  logic bit_ready;

  modport master (
    output bit_data,
    output bit_valid,
    input  bit_ready
  );

  modport slave (
    input  bit_data,
    input  bit_valid,
    output bit_ready
  );
endinterface

// File: rtl/fsk_nco_modulator.sv
// Binary FSK modulator: queues serial bits in a small FIFO and holds each bit
// for SAMPLES_PER_BIT sample ticks. A phase-accumulator NCO drives a full-wave
// sine LUT and produces offset-binary samples. The phase runs continuously
// across bit boundaries and tone changes. The mark tone is sent when idle.
// Ports:
//   clk            : clock
//   reset          : asynchronous, active-low reset
//   i_clr          : synchronous soft clear, same effect as reset
//   i_sample_en    : one-clk sample tick
//   i_inc_space    : phase increment for bit 0
//   i_inc_mark     : phase increment for bit 1 and idle
//   bit_if         : bit stream handshake (slave side)
//   o_sample       : sine sample, offset binary
//   o_sample_valid : one-clk pulse, sample updated this cycle
//   o_busy         : a bit is being sent or the FIFO is non-empty
//   o_underrun     : one-clk pulse, bit stream ended with the FIFO empty
module fsk_nco_modulator #(
  parameter int OUT_W           = 8,
  parameter int PHASE_W         = 16,
  parameter int LUT_AW          = 5,
  parameter int SAMPLES_PER_BIT = 32,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clr,
  input  logic                  i_sample_en,
  input  logic [PHASE_W-1:0]    i_inc_space,
  input  logic [PHASE_W-1:0]    i_inc_mark,
  fsk_nco_modulator_if.slave    bit_if,
  output logic [OUT_W-1:0]      o_sample,
  output logic                  o_sample_valid,
  output logic                  o_busy,
  output logic                  o_underrun
);

  localparam int LUT_N = 1 << LUT_AW;
  localparam int MID   = 1 << (OUT_W - 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int BC_W  = $clog2(SAMPLES_PER_BIT + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] DATA = 1'b1;

  // Sine table built at elaboration, rounding half away from zero.
  logic [OUT_W-1:0] w_lut [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam real ANG = 2.0 * 3.14159265358979323846 * real'(k) / real'(LUT_N);
    localparam real AMP = real'(MID - 1) * $sin(ANG);
    localparam int  RND = (AMP >= 0.0) ? $rtoi(AMP + 0.5) : -$rtoi(0.5 - AMP);
    assign w_lut[k] = OUT_W'(MID + RND);
  end

  logic [PHASE_W-1:0] r_phase;
  logic [0:0]         r_state;
  logic [BC_W-1:0]    r_cnt;
  logic               r_cur_bit;
  logic               r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_ready;
  logic [OUT_W-1:0]   r_sample;
  logic               r_sample_valid;
  logic               r_busy;
  logic               r_underrun;

  logic               w_empty;
  logic               w_push;
  logic               w_bit_end;
  logic               w_pop;
  logic               w_tone;
  logic [0:0]         w_state_next;
  logic [CNT_W-1:0]   w_count_next;
  logic [LUT_AW-1:0]  w_addr;

  assign w_empty   = (r_count == '0);
  assign w_push    = bit_if.bit_valid && r_ready;
  assign w_bit_end = (r_state == IDLE) || (r_cnt == BC_W'(SAMPLES_PER_BIT));
  assign w_pop     = i_sample_en && w_bit_end && !w_empty;
  assign w_addr    = r_phase[PHASE_W-1 -: LUT_AW];

  // At a bit boundary the tone comes from the FIFO head, or mark when empty.
  always_comb begin
    w_tone       = r_cur_bit;
    w_state_next = r_state;
    if (i_sample_en && w_bit_end) begin
      w_tone       = w_empty ? 1'b1 : r_mem[r_rd_ptr];
      w_state_next = w_empty ? IDLE : DATA;
    end
  end

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase        <= '0;
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_cur_bit      <= 1'b0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_ready        <= 1'b1;
      r_sample       <= OUT_W'(MID);
      r_sample_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_underrun     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 1'b0;
    end else if (i_clr) begin
      r_phase        <= '0;
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_cur_bit      <= 1'b0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_ready        <= 1'b1;
      r_sample       <= OUT_W'(MID);
      r_sample_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_underrun     <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= bit_if.bit_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_cur_bit <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
      r_count        <= w_count_next;
      r_ready        <= (w_count_next != CNT_W'(FIFO_DEPTH));
      r_busy         <= (w_state_next == DATA) || (w_count_next != '0);
      r_state        <= w_state_next;
      r_sample_valid <= i_sample_en;
      r_underrun     <= i_sample_en && w_bit_end && w_empty && (r_state == DATA);
      if (i_sample_en) begin
        // Sample uses the pre-increment phase.
        r_sample <= w_lut[w_addr];
        r_phase  <= r_phase + (w_tone ? i_inc_mark : i_inc_space);
        if (!w_bit_end)   r_cnt <= r_cnt + 1'b1;
        else if (w_empty) r_cnt <= '0;
        else              r_cnt <= BC_W'(1);
      end
    end
  end

  assign bit_if.bit_ready = r_ready;
  assign o_sample         = r_sample;
  assign o_sample_valid   = r_sample_valid;
  assign o_busy           = r_busy;
  assign o_underrun       = r_underrun;

endmodule

// File: tb/tb_fsk_nco_modulator.sv
// Self-checking bench for fsk_nco_modulator. Stimulus queues the expected
// sample/underrun for each tick; a monitor pops and compares whenever the DUT
// raises sample_valid. SAMPLES_PER_BIT is 4 so bit boundaries come quickly.
module tb_fsk_nco_modulator;

  localparam int SPB = 4;

  typedef struct {
    logic [7:0] sample;
    logic       underrun;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        clr;
  logic        sampleEn;
  logic [15:0] incSpace;
  logic [15:0] incMark;
  logic [7:0]  sample;
  logic        sampleValid;
  logic        busy;
  logic        underrun;

  exp_t expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;

  fsk_nco_modulator_if bitIf();

  fsk_nco_modulator #(
    .OUT_W(8), .PHASE_W(16), .LUT_AW(5), .SAMPLES_PER_BIT(SPB), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_clr(clr),
    .i_sample_en(sampleEn),
    .i_inc_space(incSpace),
    .i_inc_mark(incMark),
    .bit_if(bitIf.slave),
    .o_sample(sample),
    .o_sample_valid(sampleValid),
    .o_busy(busy),
    .o_underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // One sample tick every 4 clk; the expected response is queued first.
  task automatic applyStimulus(input logic [7:0] expSample, input logic expUnderrun);
    exp_t e;
    e.sample   = expSample;
    e.underrun = expUnderrun;
    expQ.push_back(e);
    sampleEn = 1'b1;
    @(posedge clk);
    #1 sampleEn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pushBit(input logic b);
    bitIf.bit_data  = b;
    bitIf.bit_valid = 1'b1;
    @(posedge clk);
    #1 bitIf.bit_valid = 1'b0;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " sample"}, int'(sample), 128);
    checkOutput({tag, " sample_valid"}, int'(sampleValid), 0);
    checkOutput({tag, " bit_ready"}, int'(bitIf.bit_ready), 1);
    checkOutput({tag, " busy"}, int'(busy), 0);
    checkOutput({tag, " underrun"}, int'(underrun), 0);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (sampleValid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected sample_valid", 1, 0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("sample", int'(sample), int'(e.sample));
        checkOutput("underrun with sample", int'(underrun), int'(e.underrun));
      end
    end else if (underrun) begin
      checkOutput("underrun without sample_valid", 1, 0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset           = 1'b0;
    clr             = 1'b0;
    sampleEn        = 1'b0;
    incSpace        = 16'd2048;
    incMark         = 16'd4096;
    bitIf.bit_data  = 1'b0;
    bitIf.bit_valid = 1'b0;

    #12;
    checkResetValues("reset");
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] scenario 1: idle mark tone");
    applyStimulus(8'd128, 1'b0);
    applyStimulus(8'd177, 1'b0);
    applyStimulus(8'd218, 1'b0);
    applyStimulus(8'd245, 1'b0);
    applyStimulus(8'd255, 1'b0);
    checkOutput("s1 busy", int'(busy), 0);

    $display("[TB] scenario 2: one space bit then underrun");
    doReset();
    pushBit(1'b0);
    checkOutput("s2 busy after push", int'(busy), 1);
    applyStimulus(8'd128, 1'b0);
    applyStimulus(8'd153, 1'b0);
    applyStimulus(8'd177, 1'b0);
    applyStimulus(8'd199, 1'b0);
    checkOutput("s2 busy during last bit sample", int'(busy), 1);
    applyStimulus(8'd218, 1'b1);
    checkOutput("s2 busy after bit end", int'(busy), 0);
    applyStimulus(8'd245, 1'b0);

    $display("[TB] scenario 3: FIFO full");
    doReset();
    pushBit(1'b1);
    pushBit(1'b0);
    pushBit(1'b1);
    checkOutput("s3 ready after 3 pushes", int'(bitIf.bit_ready), 1);
    pushBit(1'b0);
    checkOutput("s3 ready after 4 pushes", int'(bitIf.bit_ready), 0);
    pushBit(1'b1);
    checkOutput("s3 ready after dropped push", int'(bitIf.bit_ready), 0);
    checkOutput("s3 busy", int'(busy), 1);
    applyStimulus(8'd128, 1'b0);
    checkOutput("s3 ready after pop", int'(bitIf.bit_ready), 1);
    pushBit(1'b1);
    checkOutput("s3 ready refilled", int'(bitIf.bit_ready), 0);

    $display("[TB] scenario 4: downward phase wrap");
    doReset();
    incSpace = 16'hF800;
    pushBit(1'b0);
    applyStimulus(8'd128, 1'b0);
    applyStimulus(8'd103, 1'b0);
    applyStimulus(8'd79, 1'b0);
    applyStimulus(8'd57, 1'b0);
    incSpace = 16'd2048;

    $display("[TB] scenario 5: soft clear mid-bit");
    doReset();
    pushBit(1'b1);
    applyStimulus(8'd128, 1'b0);
    pushBit(1'b0);
    pushBit(1'b1);
    applyStimulus(8'd177, 1'b0);
    checkOutput("s5 busy before clr", int'(busy), 1);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    checkOutput("s5 sample after clr", int'(sample), 128);
    checkOutput("s5 busy after clr", int'(busy), 0);
    checkOutput("s5 ready after clr", int'(bitIf.bit_ready), 1);
    applyStimulus(8'd128, 1'b0);
    applyStimulus(8'd177, 1'b0);

    $display("[TB] scenario 6: async reset mid-bit");
    doReset();
    pushBit(1'b0);
    applyStimulus(8'd128, 1'b0);
    applyStimulus(8'd153, 1'b0);
    checkOutput("s6 busy before reset", int'(busy), 1);
    #2 reset = 1'b0;
    #1;
    checkResetValues("s6 async");
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(8'd128, 1'b0);
    applyStimulus(8'd177, 1'b0);
    applyStimulus(8'd218, 1'b0);
    applyStimulus(8'd245, 1'b0);
    applyStimulus(8'd255, 1'b0);
    checkOutput("s6 busy", int'(busy), 0);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", expQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
